// File: rtl/ucsbece152a_taillights_seq_pkg.sv
// Shared mode encoding and request priority for the sequential taillight controller.
package ucsbece152a_taillights_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    // Both turn switches together are treated as a hazard request.
    function automatic mode_t req_mode(input logic left, input logic right, input logic hazard);
        if (hazard || (left && right)) return MODE_HAZARD;
        else if (left)                 return MODE_LEFT;
        else if (right)                return MODE_RIGHT;
        else                           return MODE_IDLE;
    endfunction

endpackage

// File: rtl/ucsbece152a_taillights_seq_if.sv
// Switch-input / lamp-output bundle for the taillight controller.
interface ucsbece152a_taillights_seq_if #(
    parameter int LAMPS = 3
);
    logic                 left_i;
    logic                 right_i;
    logic                 hazard_i;
    logic                 brake_i;
    logic                 runlights_i;
    logic [2*LAMPS-1:0]   lights_o;
    logic [1:0]           mode_o;

    modport master (
        output left_i, right_i, hazard_i, brake_i, runlights_i,
        input  lights_o, mode_o
    );

    modport slave (
        input  left_i, right_i, hazard_i, brake_i, runlights_i,
        output lights_o, mode_o
    );
endinterface

// File: rtl/ucsbece152a_taillights_seq_tick_gen.sv
// Sequence-step prescaler: o_tick high on the last of every TICK_DIV cycles, restartable via i_clr.
module ucsbece152a_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr)  r_cnt <= '0;
        else if (o_tick)   r_cnt <= '0;
        else               r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/ucsbece152a_taillights_seq.sv
// Parametrised sequential taillight controller: turn sweeps, hazard, brake and running lights.
// Optional dimming PWM is built when TAILLIGHTS_DIM_EN is defined; otherwise running lights are full-on.
module ucsbece152a_taillights_seq
    import ucsbece152a_taillights_pkg::*;
#(
    parameter int          LAMPS    = 3,
    parameter int          TICK_DIV = 1,
    parameter int          PWM_BITS = 4,
    parameter int unsigned DIM_DUTY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    ucsbece152a_taillights_seq_if.slave    bus
);
    localparam int SEQ_W = $clog2(LAMPS + 1);

    mode_t            r_mode;
    logic [SEQ_W-1:0] r_seq;
    mode_t            w_req;
    logic             w_chg;
    logic             w_idle;
    logic             w_tick;
    logic             w_dim;
    logic             w_lseq;
    logic             w_rseq;
    logic             w_fill;
    logic [2*LAMPS-1:0] w_lights;

    assign w_req  = req_mode(bus.left_i, bus.right_i, bus.hazard_i);
    assign w_chg  = (w_req != r_mode);
    assign w_idle = (r_mode == MODE_IDLE);

    ucsbece152a_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_chg || w_idle),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_IDLE;
            r_seq  <= '0;
        end else begin
            r_mode <= w_req;
            if (w_chg || w_idle)
                r_seq <= '0;
            else if (w_tick)
                r_seq <= (r_seq == SEQ_W'(LAMPS)) ? '0 : r_seq + 1'b1;
        end
    end

`ifdef TAILLIGHTS_DIM_EN
    logic [PWM_BITS-1:0] r_pwm;

    always_ff @(posedge clk) begin
        if (rst) r_pwm <= '0;
        else     r_pwm <= r_pwm + 1'b1;
    end

    assign w_dim = (32'(r_pwm) < DIM_DUTY);
`else
    assign w_dim = 1'b1;
`endif

    assign w_lseq = (r_mode == MODE_LEFT)  || (r_mode == MODE_HAZARD);
    assign w_rseq = (r_mode == MODE_RIGHT) || (r_mode == MODE_HAZARD);
    // A side not sequencing is filled by brake, or by running lights at dim level.
    assign w_fill = bus.brake_i || (bus.runlights_i && w_dim);

    always_comb begin
        w_lights = '0;
        for (int i = 0; i < LAMPS; i++) begin
            w_lights[LAMPS+i]   = w_lseq ? (SEQ_W'(i) < r_seq) : w_fill;
            w_lights[LAMPS-1-i] = w_rseq ? (SEQ_W'(i) < r_seq) : w_fill;
        end
    end

    assign bus.lights_o = rst ? '0 : w_lights;
    assign bus.mode_o   = rst ? 2'd0 : r_mode;
endmodule
